// File: rtl/spi_reg_responder.sv
// SPI mode-0 target with a small 8-bit register file, oversampled on clk.
// Optional burst (address auto-increment) mode: define SPI_RESP_AUTOINC_EN.
module spi_reg_responder #(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [8*NUM_REGS-1:0] regs_out,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [7:0]            wr_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;

  state_t                      state_q, state_d;
  logic                        armed_q, armed_d;
  logic [2:0]                  bit_cnt_q, bit_cnt_d;
  logic [7:0]                  shift_in_q, shift_in_d;
  logic [6:0]                  shift_out_q, shift_out_d;
  logic                        rw_q, rw_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [NUM_REGS-1:0][7:0]    regs_q;
  logic                        miso_q, miso_d;
  logic                        oe_q, oe_d;
  logic                        strobe_q, strobe_d;
  logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;
  logic [7:0]                  wr_data_q, wr_data_d;
  logic                        reg_we;
  logic [7:0]                  new_byte;
  logic [ADDR_W-1:0]           nxt_addr;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign new_byte  = {shift_in_q[6:0], mosi_s};

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign regs_out    = regs_q;
  assign wr_strobe   = strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

  // Next-state and datapath decode
  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | cs_s;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    rw_d        = rw_q;
    nxt_addr    = addr_q;
    miso_d      = miso_q;
    strobe_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // armed only after cs_n has been seen high, so a frame cut by reset is ignored
        if (armed_q && !cs_s) begin
          state_d   = ST_CMD;
          bit_cnt_d = 3'd0;
        end
      end
      ST_CMD: begin
        if (cs_s) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          shift_in_d = new_byte;
          bit_cnt_d  = 3'(bit_cnt_q + 3'd1);
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d   = 3'd0;
            rw_d        = new_byte[7];
            nxt_addr    = new_byte[ADDR_W-1:0];
            shift_out_d = regs_q[nxt_addr][6:0];
            miso_d      = regs_q[nxt_addr][7];
            state_d     = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cs_s) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          shift_in_d = new_byte;
          bit_cnt_d  = 3'(bit_cnt_q + 3'd1);
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            if (!rw_q) begin
              reg_we    = 1'b1;
              strobe_d  = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = new_byte;
            end
`ifdef SPI_RESP_AUTOINC_EN
            nxt_addr = ADDR_W'(addr_q + 1'b1);
            if (rw_q) begin
              shift_out_d = regs_q[nxt_addr][6:0];
              miso_d      = regs_q[nxt_addr][7];
            end
`else
            state_d = ST_DONE;
`endif
          end
        end else if (sclk_fall && rw_q && (bit_cnt_q != 3'd0)) begin
          // the fall right after a byte boundary keeps the freshly loaded MSB
          miso_d      = shift_out_q[6];
          shift_out_d = {shift_out_q[5:0], 1'b0};
        end
      end
      ST_DONE: begin
        if (cs_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    addr_d = nxt_addr;
    if ((state_d != ST_DATA) || !rw_d) begin
      miso_d = 1'b0;
    end
    oe_d = (state_d != ST_IDLE) && !cs_s;
  end

  // Synchronisers, FSM state and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync   <= '0;
      cs_sync     <= '0;
      mosi_sync   <= '0;
      sclk_prev   <= 1'b0;
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      bit_cnt_q   <= 3'd0;
      shift_in_q  <= 8'd0;
      shift_out_q <= 7'd0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      regs_q      <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      strobe_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
    end else begin
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync     <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync   <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev   <= sclk_s;
      state_q     <= state_d;
      armed_q     <= armed_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      strobe_q    <= strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      if (reg_we) begin
        regs_q[wr_addr_d] <= wr_data_d;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
// Randomised bench for spi_reg_responder: a host drives frames on the pins and a
// byte-level register model predicts writes, strobes, MISO bytes and output enable.
module tb_spi_reg_responder;

  localparam int unsigned NUM_REGS    = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned ADDR_W      = 2;
  localparam int          HALF        = 6;
  localparam int          LAT         = SYNC_STAGES + 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  spi_sclk = 1'b0;
  logic                  spi_cs_n = 1'b1;
  logic                  spi_mosi = 1'b0;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic [8*NUM_REGS-1:0] regs_out;
  logic                  wr_strobe;
  logic [ADDR_W-1:0]     wr_addr;
  logic [7:0]            wr_data;

  spi_reg_responder #(.NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .regs_out(regs_out),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } wr_t;

  int         checks = 0;
  int         errors = 0;
  int         strobe_cnt = 0;
  wr_t        exp_q[$];
  logic [7:0] model_regs [NUM_REGS];
  logic [7:0] tx_buf [4];
  logic [7:0] rx_buf [4];
  bit         blocked = 1'b1;
  bit         prev_strobe = 1'b0;
  int         cs_hi_cnt = 0;
  int         cs_lo_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8*NUM_REGS-1:0] model_flat();
    logic [8*NUM_REGS-1:0] f;
    for (int i = 0; i < NUM_REGS; i++) f[8*i +: 8] = model_regs[i];
    return f;
  endfunction

  // Per-cycle compare against the register model
  initial begin
    for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'd0;
    forever begin
      @(negedge clk);
      if (wr_strobe) begin
        strobe_cnt++;
        chk("strobe_width", 64'(prev_strobe), 64'(0));
        chk("strobe_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(e.a));
          chk("wr_data", 64'(wr_data), 64'(e.d));
          model_regs[e.a] = e.d;
        end
      end
      prev_strobe = wr_strobe;
      chk("regs_out", 64'(regs_out), 64'(model_flat()));
      if (blocked || cs_hi_cnt > LAT) begin
        chk("oe_inactive", 64'(spi_miso_oe), 64'(0));
        chk("miso_inactive", 64'(spi_miso), 64'(0));
      end else if (cs_lo_cnt > LAT) begin
        chk("oe_active", 64'(spi_miso_oe), 64'(1));
      end
      if (rst) begin
        blocked = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = 8'd0;
        exp_q.delete();
      end else if (spi_cs_n) begin
        blocked = 1'b0;
      end
      if (spi_cs_n) begin
        cs_hi_cnt++;
        cs_lo_cnt = 0;
      end else begin
        cs_lo_cnt++;
        cs_hi_cnt = 0;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clock_bit(input logic b, output logic s);
    spi_mosi = b;
    wait_cyc(HALF);
    spi_sclk = 1'b1;
    s = spi_miso;
    wait_cyc(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic frame(input int nbits);
    logic s;
    for (int k = 0; k < 4; k++) rx_buf[k] = 8'd0;
    spi_cs_n = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < nbits; i++) begin
      clock_bit(tx_buf[i/8][7-(i%8)], s);
      rx_buf[i/8][7-(i%8)] = s;
    end
    wait_cyc(HALF);
    spi_cs_n = 1'b1;
    wait_cyc(3*HALF);
  endtask

  // Predict a frame from the command byte, run it, then check MISO bytes and drained writes
  task automatic run_frame(input int nbits);
    logic [7:0]        cmd;
    logic [ADDR_W-1:0] a;
    logic [7:0]        exp_rx [4];
    logic [7:0]        mask;
    int                nfull, active, rd_lim, cnt;
    cmd   = tx_buf[0];
    a     = cmd[ADDR_W-1:0];
    nfull = (nbits >= 8) ? (nbits - 8) / 8 : 0;
`ifdef SPI_RESP_AUTOINC_EN
    active = nfull;
    rd_lim = 4;
`else
    active = (nfull > 1) ? 1 : nfull;
    rd_lim = 1;
`endif
    for (int k = 0; k < 4; k++) begin
      exp_rx[k] = 8'd0;
      if (k >= 1 && nbits >= 8 && cmd[7] && (k - 1) < rd_lim)
        exp_rx[k] = model_regs[ADDR_W'(int'(a) + k - 1)];
    end
    if (nbits >= 8 && !cmd[7]) begin
      for (int k = 1; k <= active; k++) begin
        wr_t e;
        e.a = ADDR_W'(int'(a) + k - 1);
        e.d = tx_buf[k];
        exp_q.push_back(e);
      end
    end
    frame(nbits);
    for (int k = 0; k < (nbits + 7) / 8; k++) begin
      cnt  = ((nbits - 8*k) > 8) ? 8 : (nbits - 8*k);
      mask = 8'hFF;
      mask = mask << (8 - cnt);
      chk("miso_byte", 64'(rx_buf[k] & mask), 64'(exp_rx[k] & mask));
    end
    chk("writes_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int s0;
    logic s;
    wait_cyc(2);
    rst = 1'b0;
    chk("reset_regs", 64'(regs_out), 64'(0));
    chk("reset_oe", 64'(spi_miso_oe), 64'(0));
    chk("reset_strobe", 64'(wr_strobe), 64'(0));
    wait_cyc(2*HALF);

    // write reg2 = A5
    s0 = strobe_cnt;
    tx_buf[0] = 8'h02; tx_buf[1] = 8'hA5;
    run_frame(16);
    chk("lit_reg2", 64'(regs_out[23:16]), 64'(8'hA5));
    chk("lit_regs_a", 64'(regs_out), 64'(32'h00A5_0000));
    chk("lit_one_strobe", 64'(strobe_cnt - s0), 64'(1));
    chk("lit_wr_addr", 64'(wr_addr), 64'(2));
    chk("lit_wr_data", 64'(wr_data), 64'(8'hA5));

    // read reg2
    tx_buf[0] = 8'h82; tx_buf[1] = 8'h00;
    run_frame(16);
    chk("lit_read_a5", 64'(rx_buf[1]), 64'(8'hA5));
    chk("lit_oe_after_cs", 64'(spi_miso_oe), 64'(0));

    // partial write then full write
    s0 = strobe_cnt;
    tx_buf[0] = 8'h01; tx_buf[1] = 8'hFF;
    run_frame(13);
    chk("lit_partial_regs", 64'(regs_out), 64'(32'h00A5_0000));
    chk("lit_partial_nostrobe", 64'(strobe_cnt - s0), 64'(0));
    tx_buf[0] = 8'h01; tx_buf[1] = 8'h3C;
    run_frame(16);
    chk("lit_regs_b", 64'(regs_out), 64'(32'h00A5_3C00));

    // reset in the middle of a read data byte; remainder looks like a write
    tx_buf[0] = 8'h82;
    spi_cs_n = 1'b0;
    wait_cyc(HALF);
    for (int i = 0; i < 12; i++) clock_bit(tx_buf[0][7-(i%8)], s);
    rst = 1'b1;
    wait_cyc(1);
    chk("lit_oe_reset_mid", 64'(spi_miso_oe), 64'(0));
    rst = 1'b0;
    tx_buf[1] = 8'h01;
    tx_buf[2] = 8'hFF;
    for (int i = 0; i < 16; i++) clock_bit(tx_buf[1 + i/8][7-(i%8)], s);
    wait_cyc(HALF);
    spi_cs_n = 1'b1;
    wait_cyc(3*HALF);
    chk("lit_regs_after_rst", 64'(regs_out), 64'(0));
    tx_buf[0] = 8'h02; tx_buf[1] = 8'h5A;
    run_frame(16);
    tx_buf[0] = 8'h82; tx_buf[1] = 8'h00;
    run_frame(16);
    chk("lit_read_5a", 64'(rx_buf[1]), 64'(8'h5A));

    // three-byte write from reg3
    s0 = strobe_cnt;
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
    run_frame(24);
`ifdef SPI_RESP_AUTOINC_EN
    chk("lit_burst_regs", 64'(regs_out), 64'(32'h115A_0022));
    chk("lit_burst_strobes", 64'(strobe_cnt - s0), 64'(2));
`else
    chk("lit_single_regs", 64'(regs_out), 64'(32'h115A_0000));
    chk("lit_single_strobes", 64'(strobe_cnt - s0), 64'(1));
`endif

    // random frames
    for (int n = 0; n < 40; n++) begin
      int nd, nb;
      for (int k = 0; k < 4; k++) tx_buf[k] = 8'($urandom);
      nd = int'($urandom_range(0, 2));
      nb = 8 + 8*nd;
      if ($urandom_range(0, 3) == 0) nb = nb + int'($urandom_range(1, 7));
      if ($urandom_range(0, 9) == 0) nb = int'($urandom_range(1, 7));
      run_frame(nb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 responder (target) with a small read/write register file, oversampled on the system clock.
- It is the far end of the host-driven pin interface: the host (bench or external MCU) initiates transactions on pins; this block answers on MISO.
- Register contents drive design logic through a flat output bus.
- Each write emits a one-cycle strobe.

Parameters:
- NUM_REGS, 4, number of 8-bit registers; power of two, 2..16; ADDR_W = clog2(NUM_REGS).
- SYNC_STAGES, 2, synchroniser depth on sclk/cs_n/mosi; minimum 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- spi_sclk  input  1  SPI clock from host, asynchronous to clk.
- spi_cs_n  input  1  chip select from host, active low, asynchronous.
- spi_mosi  input  1  host-to-responder data, asynchronous.
- spi_miso  output  1  responder-to-host data.
- spi_miso_oe  output  1  MISO output enable; maps to a uio_oe bit.
- regs_out  output  8*NUM_REGS  register file, reg i at bits [8i+7:8i].
- wr_strobe  output  1  one-cycle pulse when a register is written.
- wr_addr  output  ADDR_W  address of the last write.
- wr_data  output  8  data of the last write.

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named rst.
- Reset values: all registers, spi_miso, spi_miso_oe, wr_strobe, wr_addr and wr_data are 0; FSM goes to IDLE.
- Synchronisation and edge detection:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Rise/fall of sclk is detected from the last two synchronised samples.
- Host timing requirement: sclk high and low phases each ≥ SYNC_STAGES+2 clk cycles. Behaviour is undefined if this is violated.
- Frame format (MSB first):
  - Command byte: bit7 = 1 read / 0 write; bits[ADDR_W-1:0] = addr; other bits ignored.
  - Followed by data bytes.
- Timing: MOSI sampled on synchronised sclk rise; MISO updated on synchronised sclk fall.
- FSM states:
  - IDLE: waits for synced cs_n low, then clears the bit counter and goes to CMD.
  - CMD: shifts 8 bits. On the 8th rise, latches rw/addr and goes to DATA. On a read, the shift-out register loads regs[addr] and spi_miso presents its MSB within 1 clk, before the first data-byte rise.
  - DATA, write: after the 8th rise, regs[addr] is updated on the next clk edge. wr_strobe pulses for exactly 1 cycle with wr_addr/wr_data valid in that same cycle. Then goes to DONE.
  - DATA, read: shifts out regs[addr] one bit per fall; bit 7 is already presented. After the 8th rise, goes to DONE.
  - DONE: ignores further sclk edges; spi_miso = 0.
- spi_miso is 0 in IDLE, CMD and DONE.
- spi_miso_oe = 1 whenever synced cs_n is low and the FSM is not IDLE; otherwise 0.
- cs_n rising in any state: return to IDLE next cycle; spi_miso_oe and spi_miso drop to 0.
  - A partial byte is discarded. A write with < 8 data bits commits nothing and gives no strobe.
- Read-during-write: the register value sampled at the CMD→DATA transition is what is shifted out. A later write in the same clk does not change bits already loaded.
- rst asserted mid-frame clears everything immediately on that clk edge. The remainder of the host frame is ignored until cs_n goes high then low again; IDLE requires seeing cs_n high first after reset.
- Out-of-range address is impossible; the address is truncated to ADDR_W bits.

Optional Feature:
- Macro SPI_RESP_AUTOINC_EN.
- Defined: burst mode.
  - After each full data byte, addr increments modulo NUM_REGS and the FSM stays in DATA (no DONE).
  - Reads reload the shift register with the new regs[addr] on the same cycle as the 8th rise.
  - Writes commit each byte with its own wr_strobe.
- Undefined: single-byte transfers exactly as above; extra bytes are ignored.

Test Plan:
- Reset: hold rst 2 cycles → regs_out = 0, spi_miso_oe = 0, wr_strobe = 0.
- Write 0x02 then 0xA5 → regs_out[23:16] = 0xA5; wr_strobe high exactly 1 cycle with wr_addr = 2, wr_data = 0xA5; other registers unchanged.
- After the write above, read 0x82 → MISO bits during data byte = 0xA5; spi_miso_oe high only while cs_n is low.
- Write 0x01 plus 5 data bits, then cs_n high → reg1 unchanged at 0, no wr_strobe; the next full write 0x01/0x3C succeeds.
- Assert rst mid-data-byte of a read → spi_miso_oe = 0 next cycle; the rest of the frame is ignored; a new frame after a cs_n toggle reads correctly.
- With SPI_RESP_AUTOINC_EN: write 0x03, 0x11, 0x22 → reg3 = 0x11, reg0 = 0x22 (wrap), two strobes. Without the macro: only reg3 = 0x11, one strobe.
